ttt_game_ctrl: RTL



---
 rtl/ttt_pkg.sv | 31 +++
 rtl/ttt_game_ctrl_if.sv | 25 ++
 rtl/ttt_line_check.sv | 31 +++
 rtl/ttt_game_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and encodings for the tic-tac-toe turn sequencer and its helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ttt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_KEY,
        PLACE,
        CHECK,
        OVER
    } state_t;

    localparam logic [1:0] RES_PLAY = 2'b00;
    localparam logic [1:0] RES_XWIN = 2'b01;
    localparam logic [1:0] RES_OWIN = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Cell k (1..9, row-major from top-left) lives at board[19-2k : 18-2k];
    // this returns the low bit index 18-2k.
    function automatic logic [4:0] cell_lsb(input logic [3:0] k);
        return 5'd18 - {k, 1'b0};
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Key-event inputs and board/status outputs of the turn sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: none; key events are single-cycle pulses and are dropped when not accepted.
// Ports: start, key_valid, key_code[3:0] (master -> slave);
//        board[17:0], turn_o, result[1:0], in_game, move_err (slave -> master).
interface ttt_game_ctrl_if;
    logic        start;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result;
    logic        in_game;
    logic        move_err;

    modport master (
        output start, key_valid, key_code,
        input  board, turn_o, result, in_game, move_err
    );

    modport slave (
        input  start, key_valid, key_code,
        output board, turn_o, result, in_game, move_err
    );
endinterface

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player over the 18-bit board.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_board[17:0] board vector, i_player (1 = O, 0 = X), o_win line complete.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    input  logic        i_player,
    output logic        o_win
);

    logic [1:0] w_code;
    logic [8:0] w_m;    // w_m[i] : cell i+1 holds the player's stone

    assign w_code = i_player ? CELL_O : CELL_X;

    for (genvar g = 0; g < 9; g++) begin : g_cell
        assign w_m[g] = (i_board[cell_lsb(4'(g + 1)) +: 2] == w_code);
    end

    assign o_win = (w_m[0] & w_m[1] & w_m[2]) |
                   (w_m[3] & w_m[4] & w_m[5]) |
                   (w_m[6] & w_m[7] & w_m[8]) |
                   (w_m[0] & w_m[3] & w_m[6]) |
                   (w_m[1] & w_m[4] & w_m[7]) |
                   (w_m[2] & w_m[5] & w_m[8]) |
                   (w_m[0] & w_m[4] & w_m[8]) |
                   (w_m[2] & w_m[4] & w_m[6]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: validates key moves, commits stones, scores win/draw, alternates players.
// Latency: legal key at edge t -> board after t+1, result/turn_o after t+2; move_err the cycle after t.
// Backpressure: none; keys outside WAIT_KEY are dropped, so keys must be spaced at least 3 cycles.
// Ports: clk, rst (async active-high), ttt_bus (slave modport of ttt_game_ctrl_if).
module ttt_game_ctrl
    import ttt_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ttt_game_ctrl_if.slave  ttt_bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_board;
    logic        r_turn_o;
    logic [1:0]  r_result;
    logic        r_move_err;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cell;
    logic        w_win;
    logic        w_key_ok;
    logic        w_in_game;

    // r_turn_o has not toggled yet in CHECK, so it names the player who just moved.
    ttt_line_check u_line_check (
        .i_board  (r_board),
        .i_player (r_turn_o),
        .o_win    (w_win)
    );

    // Only codes 1..9 can match here, so out-of-range codes fall through as illegal.
    always_comb begin
        w_key_ok = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (ttt_bus.key_code == 4'(k)) begin
                w_key_ok = (r_board[cell_lsb(4'(k)) +: 2] == CELL_EMPTY);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start overrides everything, including a same-cycle key.
    always_comb begin
        w_state_nxt = r_state;
        if (ttt_bus.start) begin
            w_state_nxt = WAIT_KEY;
        end else begin
            case (r_state)
                IDLE:     w_state_nxt = IDLE;
                WAIT_KEY: if (ttt_bus.key_valid && w_key_ok) w_state_nxt = PLACE;
                PLACE:    w_state_nxt = CHECK;
                CHECK:    w_state_nxt = (w_win || r_cnt == MAX_MOVES) ? OVER : WAIT_KEY;
                OVER:     w_state_nxt = OVER;
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        w_in_game = (r_state == WAIT_KEY) || (r_state == PLACE) || (r_state == CHECK);
    end

    // Registered datapath: board, turn, result, move counter, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board    <= '0;
            r_turn_o   <= 1'b0;
            r_result   <= RES_PLAY;
            r_move_err <= 1'b0;
            r_cnt      <= '0;
            r_cell     <= '0;
        end else begin
            r_move_err <= 1'b0;
            if (ttt_bus.start) begin
                r_board  <= '0;
                r_turn_o <= 1'b0;
                r_result <= RES_PLAY;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    WAIT_KEY: begin
                        if (ttt_bus.key_valid) begin
                            if (w_key_ok) r_cell <= ttt_bus.key_code;
                            else          r_move_err <= 1'b1;
                        end
                    end
                    PLACE: begin
                        r_board[cell_lsb(r_cell) +: 2] <= r_turn_o ? CELL_O : CELL_X;
                        r_cnt <= (r_cnt == MAX_MOVES) ? MAX_MOVES : r_cnt + 4'd1;
                    end
                    CHECK: begin
                        // Win is tested before the move count so a ninth-move win is not a draw.
                        if (w_win)                   r_result <= r_turn_o ? RES_OWIN : RES_XWIN;
                        else if (r_cnt == MAX_MOVES) r_result <= RES_DRAW;
                        else                         r_turn_o <= ~r_turn_o;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ttt_bus.board    = r_board;
    assign ttt_bus.turn_o   = r_turn_o;
    assign ttt_bus.result   = r_result;
    assign ttt_bus.move_err = r_move_err;
    assign ttt_bus.in_game  = w_in_game;

endmodule
